// File: rtl/booth_wallace_mult_pipe.sv
// Three-stage radix-4 Booth / Wallace-tree signed multiplier with valid/ready handshake and sideband tag.
// Define MULT_ROUND_EN to round the product half-up when OUT_W < 2*WIDTH; otherwise it is truncated.
module booth_wallace_mult_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OUT_W = 2 * WIDTH,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] p,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned ND   = WIDTH / 2;
    localparam int unsigned NR   = ND + 1;
    localparam int unsigned SH   = PW - OUT_W;
    localparam int unsigned SHM1 = (SH == 0) ? 0 : SH - 1;
`ifdef MULT_ROUND_EN
    localparam logic [PW-1:0] RND = (SH == 0) ? '0 : (PW'(1) << SHM1);
`else
    localparam logic [PW-1:0] RND = '0;
`endif

    logic             w_adv;
    logic [WIDTH:0]   w_bx;
    logic [PW-1:0]    w_ax;
    logic [PW-1:0]    w_pp [NR];
    logic [PW-1:0]    w_c;
    logic [PW-1:0]    w_s;

    logic             r_v1, r_v2, r_v3;
    logic [TAG_W-1:0] r_t1, r_t2, r_t3;
    logic [PW-1:0]    r_pp [NR];
    logic [PW-1:0]    r_c, r_s;
    logic [OUT_W-1:0] r_p;

    assign w_adv     = !r_v3 || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v3;
    assign p         = r_p;
    assign out_tag   = r_t3;

    assign w_bx = {b, 1'b0};
    assign w_ax = {{WIDTH{a[WIDTH-1]}}, a};

    // Booth row selection; negated rows are stored inverted and the +1 lands in the last (correction) row
    always_comb begin
        logic [2:0]    trip;
        logic [PW-1:0] mag;
        logic          neg;
        trip = '0;
        mag  = '0;
        neg  = 1'b0;
        for (int unsigned k = 0; k < NR; k++) begin
            w_pp[k] = '0;
        end
        for (int unsigned i = 0; i < ND; i++) begin
            trip = w_bx[2*i +: 3];
            case (trip)
                3'b001, 3'b010, 3'b101, 3'b110: mag = w_ax;
                3'b011, 3'b100:                 mag = w_ax << 1;
                default:                        mag = '0;
            endcase
            neg = trip[2] && (trip != 3'b111);
            w_pp[i]     = (neg ? ~mag : mag) << (2 * i);
            w_pp[ND][2*i] = neg;
        end
    end

    // Wallace reduction: each level compresses every full triple of rows with 3:2 counters
    always_comb begin
        logic [PW-1:0] cur [NR];
        logic [PW-1:0] nxt [NR];
        int unsigned   cnt, ng, rem;
        cur = r_pp;
        nxt = r_pp;
        cnt = NR;
        ng  = 0;
        rem = 0;
        for (int unsigned l = 0; l < NR; l++) begin
            nxt = cur;
            if (cnt > 2) begin
                ng  = cnt / 3;
                rem = cnt % 3;
                for (int unsigned g = 0; g < NR / 3; g++) begin
                    if (g < ng) begin
                        nxt[2*g]   = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
                        nxt[2*g+1] = ((cur[3*g] & cur[3*g+1]) | (cur[3*g] & cur[3*g+2])
                                     | (cur[3*g+1] & cur[3*g+2])) << 1;
                    end
                end
                for (int unsigned k = 0; k < 2; k++) begin
                    if (k < rem) begin
                        nxt[2*ng+k] = cur[3*ng+k];
                    end
                end
                cnt = 2 * ng + rem;
            end
            cur = nxt;
        end
        w_s = cur[0];
        w_c = cur[1];
    end

    // Lock-step pipeline: all stages advance together or hold together
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_t1 <= '0;
            r_t2 <= '0;
            r_t3 <= '0;
            r_pp <= '{default: '0};
            r_c  <= '0;
            r_s  <= '0;
            r_p  <= '0;
        end else if (w_adv) begin
            r_v1 <= in_valid;
            r_t1 <= in_tag;
            r_pp <= w_pp;
            r_v2 <= r_v1;
            r_t2 <= r_t1;
            r_c  <= w_c;
            r_s  <= w_s;
            r_v3 <= r_v2;
            r_t3 <= r_t2;
            r_p  <= OUT_W'((r_c + r_s + RND) >> SH);
        end
    end

endmodule
